// File: rtl/led_sel_ctrl_if.sv
// Event/display bundle between the seller front panel logic and the
// LED mode sequencer. The master side delivers single-cycle event
// pulses; the slave side (the sequencer) returns the registered mode
// select code plus mode/busy status.
interface led_sel_ctrl_if;
  logic [3:0] key;
  logic       done;
  logic       err;
  logic [7:0] sel_n;
  logic [2:0] mode;
  logic       busy;

  modport master (
    output key,
    output done,
    output err,
    input  sel_n,
    input  mode,
    input  busy
  );

  modport slave (
    input  key,
    input  done,
    input  err,
    output sel_n,
    output mode,
    output busy
  );
endinterface

// File: rtl/led_sel_ctrl.sv
// LED mode sequencer: turns single-cycle key/done/err pulses into timed
// display modes (idle, item 1-4, dispense flash, error pulse) and drives
// the active-low one-hot select bus of the LED multiplexer. Every mode
// except idle is closed by a shared down-counting timer.
module led_sel_ctrl #(
  parameter int HOLD_CYC  = 50_000_000,
  parameter int FLASH_CYC = 25_000_000,
  parameter int PULSE_CYC = 12_500_000,
  parameter int CNT_W     = 26
) (
  input  logic           clk,
  input  logic           rst,
  led_sel_ctrl_if.slave  bus
);

  // State encoding doubles as the externally visible mode number.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ITEM1 = 3'd1,
    ST_ITEM2 = 3'd2,
    ST_ITEM3 = 3'd3,
    ST_ITEM4 = 3'd4,
    ST_FLASH = 3'd5,
    ST_PULSE = 3'd6
  } state_t;

  // Timer load values: a mode lasting N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [7:0]       sel_n_q;
  logic [2:0]       mode_q;
  logic             busy_q;
  logic             key_any;
  logic             timeout;

  // Lowest set key bit wins; the caller guarantees at least one bit set.
  function automatic state_t item_of(input logic [3:0] k);
    state_t s;
    if (k[0])      s = ST_ITEM1;
    else if (k[1]) s = ST_ITEM2;
    else if (k[2]) s = ST_ITEM3;
    else           s = ST_ITEM4;
    return s;
  endfunction

  // Fixed multiplexer codes; bit 7 stays 0 because the mux compares
  // against zero-extended 7-bit values.
  function automatic logic [7:0] sel_code(input state_t s);
    logic [7:0] c;
    case (s)
      ST_IDLE:  c = 8'h3F;
      ST_ITEM1: c = 8'h5F;
      ST_ITEM2: c = 8'h6F;
      ST_ITEM3: c = 8'h77;
      ST_ITEM4: c = 8'h7B;
      ST_FLASH: c = 8'h7D;
      ST_PULSE: c = 8'h7E;
      default:  c = 8'h3F;
    endcase
    return c;
  endfunction

  assign key_any = |bus.key;
  assign timeout = (count_q == '0);

  // Next-state and timer logic, priority err > done > key > timeout.
  always_comb begin
    state_d = state_q;
    count_d = timeout ? count_q : count_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (bus.err) begin
          state_d = ST_PULSE;
          count_d = PULSE_LD;
        end else if (key_any) begin
          state_d = item_of(bus.key);
          count_d = HOLD_LD;
        end
      end

      ST_ITEM1, ST_ITEM2, ST_ITEM3, ST_ITEM4: begin
        if (bus.err) begin
          state_d = ST_PULSE;
          count_d = PULSE_LD;
        end else if (bus.done) begin
          state_d = ST_FLASH;
          count_d = FLASH_LD;
        end else if (key_any) begin
          state_d = item_of(bus.key);
          count_d = HOLD_LD;
        end else if (timeout) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end

      ST_FLASH: begin
        if (bus.err) begin
          state_d = ST_PULSE;
          count_d = PULSE_LD;
        end else if (timeout) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end

      ST_PULSE: begin
        if (bus.err) begin
          count_d = PULSE_LD;
        end else if (timeout) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, timer and output registers; outputs are decoded from the
  // next state so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sel_n_q <= 8'h3F;
      mode_q  <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sel_n_q <= sel_code(state_d);
      mode_q  <= state_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.sel_n = sel_n_q;
  assign bus.mode  = mode_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_sel_ctrl.sv
// Testbench for led_sel_ctrl: directed scenarios followed by random
// event traffic, all checked every cycle against a deadline-based model.
module tb_led_sel_ctrl;

  localparam int HOLD  = 8;
  localparam int FLASH = 4;
  localparam int PULSE = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference model: current mode number and the edge index at which it expires.
  int   m_mode;
  int   m_deadline;
  int   t_edge;

  led_sel_ctrl_if bus();

  led_sel_ctrl #(
    .HOLD_CYC  (HOLD),
    .FLASH_CYC (FLASH),
    .PULSE_CYC (PULSE),
    .CNT_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_sel(input int m);
    case (m)
      1:       return 8'h5F;
      2:       return 8'h6F;
      3:       return 8'h77;
      4:       return 8'h7B;
      5:       return 8'h7D;
      6:       return 8'h7E;
      default: return 8'h3F;
    endcase
  endfunction

  function automatic int lowest_item(input logic [3:0] k);
    for (int i = 0; i < 4; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, t_edge, obs, exp);
    end
  endtask

  // Model update for one clock edge, from the mode rules directly.
  task automatic modelEdge(input logic [3:0] k, input logic d, input logic e, input logic r);
    t_edge++;
    if (r) begin
      m_mode = 0;
    end else if (e) begin
      m_mode = 6;
      m_deadline = t_edge + PULSE;
    end else if (d && m_mode >= 1 && m_mode <= 4) begin
      m_mode = 5;
      m_deadline = t_edge + FLASH;
    end else if (k != 4'b0 && m_mode <= 4) begin
      m_mode = lowest_item(k);
      m_deadline = t_edge + HOLD;
    end else if (m_mode != 0 && t_edge == m_deadline) begin
      m_mode = 0;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs.
  task automatic applyStimulus(input logic [3:0] k, input logic d, input logic e, input logic r);
    bus.key  = k;
    bus.done = d;
    bus.err  = e;
    rst      = r;
    @(posedge clk);
    modelEdge(k, d, e, r);
    #1;
    checkOutput("sel_n", {24'b0, bus.sel_n}, {24'b0, exp_sel(m_mode)});
    checkOutput("mode", {29'b0, bus.mode}, m_mode);
    checkOutput("busy", {31'b0, bus.busy}, {31'b0, (m_mode != 0)});
    checkOutput("sel_n_bit7", {31'b0, bus.sel_n[7]}, 32'd0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_mode     = 0;
    m_deadline = 0;
    t_edge     = 0;
    bus.key    = 4'b0;
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    rst        = 1'b1;

    // Reset while events are asserted, then one quiet cycle.
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
    idleCycles(1);

    // Item 3 hold and timeout.
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    idleCycles(10);

    // Reload with multiple keys: item1 then item2.
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    idleCycles(4);
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    idleCycles(10);

    // Dispense flow, with keys ignored during flash.
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    idleCycles(5);

    // Error preempts done; second error reloads the pulse.
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    idleCycles(1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    idleCycles(5);

    // Key in the final cycle of an item2 hold, and done while idle.
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    idleCycles(7);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    idleCycles(9);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    idleCycles(2);

    // Reset mid-mode abandons the flash immediately.
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    idleCycles(2);

    // Random sparse event traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] k;
      logic       d;
      logic       e;
      logic       r;
      k = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      d = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(k, d, e, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
